// File: rtl/blowfish128_host_driver_if.sv
// Host-side bundle for blowfish128_host_driver: key config, input/output
// block streams, core drive/return signals and status.
interface blowfish128_host_driver_if;
    logic         cfg_load;
    logic [511:0] cfg_key;
    logic [3:0]   cfg_key_length;
    logic         cfg_err;

    logic         s_valid;
    logic         s_ready;
    logic [127:0] s_data;
    logic         s_encrypt;

    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_data;
    logic         m_encrypt;

    logic         core_enable;
    logic         core_encrypt;
    logic [127:0] core_plaintext;
    logic [511:0] core_key;
    logic [3:0]   core_key_length;
    logic [127:0] core_cipher;
    logic         core_ready;

    logic         err_timeout;
    logic [15:0]  blk_count;

    // Driver side
    modport master (
        input  cfg_load, cfg_key, cfg_key_length,
        input  s_valid, s_data, s_encrypt,
        input  m_ready,
        input  core_cipher, core_ready,
        output cfg_err, s_ready,
        output m_valid, m_data, m_encrypt,
        output core_enable, core_encrypt, core_plaintext, core_key, core_key_length,
        output err_timeout, blk_count
    );

    // Host / core environment side
    modport slave (
        output cfg_load, cfg_key, cfg_key_length,
        output s_valid, s_data, s_encrypt,
        output m_ready,
        output core_cipher, core_ready,
        input  cfg_err, s_ready,
        input  m_valid, m_data, m_encrypt,
        input  core_enable, core_encrypt, core_plaintext, core_key, core_key_length,
        input  err_timeout, blk_count
    );
endinterface

// File: rtl/blowfish128_host_driver.sv
// Host-side initiator for blowfish128_top: accepts one block at a time,
// runs it through the core, returns the result, enforces an Enable-low gap
// and aborts a hung core with a watchdog.
module blowfish128_host_driver #(
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                          Clk,
    input  logic                          RstN,
    blowfish128_host_driver_if.master     bus
);

    localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [511:0]     key_q, key_d;
    logic [3:0]       klen_q, klen_d;
    logic [127:0]     pt_q, pt_d;
    logic             enc_q, enc_d;
    logic             en_q, en_d;
    logic [127:0]     mdata_q, mdata_d;
    logic             menc_q, menc_d;
    logic             mvalid_q, mvalid_d;
    logic             cfgerr_q, cfgerr_d;
    logic             tmo_q, tmo_d;
    logic [15:0]      cnt_q, cnt_d;

    logic             s_ready_c;
    logic             accept_c;
    logic             len_ok_c;
    logic             wd_last_c;
    logic             gap_done_c;

    // Key load has priority over block acceptance; nothing accepted in reset
    assign s_ready_c  = RstN && (state_q == S_IDLE) && !bus.cfg_load;
    assign accept_c   = s_ready_c && bus.s_valid;
    assign len_ok_c   = (bus.cfg_key_length != 4'd0) && (bus.cfg_key_length <= 4'd8);
    assign wd_last_c  = (wd_q == WD_W'(TIMEOUT - 1));
    assign gap_done_c = ((32'(gap_q) + 32'd1) >= GAP_CYCLES);

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!RstN) begin
            state_q  <= S_IDLE;
            wd_q     <= '0;
            gap_q    <= '0;
            key_q    <= '0;
            klen_q   <= '0;
            pt_q     <= '0;
            enc_q    <= 1'b0;
            en_q     <= 1'b0;
            mdata_q  <= '0;
            menc_q   <= 1'b0;
            mvalid_q <= 1'b0;
            cfgerr_q <= 1'b0;
            tmo_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            wd_q     <= wd_d;
            gap_q    <= gap_d;
            key_q    <= key_d;
            klen_q   <= klen_d;
            pt_q     <= pt_d;
            enc_q    <= enc_d;
            en_q     <= en_d;
            mdata_q  <= mdata_d;
            menc_q   <= menc_d;
            mvalid_q <= mvalid_d;
            cfgerr_q <= cfgerr_d;
            tmo_q    <= tmo_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        wd_d     = wd_q;
        gap_d    = gap_q;
        key_d    = key_q;
        klen_d   = klen_q;
        pt_d     = pt_q;
        enc_d    = enc_q;
        en_d     = en_q;
        mdata_d  = mdata_q;
        menc_d   = menc_q;
        mvalid_d = mvalid_q;
        cfgerr_d = 1'b0;
        tmo_d    = tmo_q;
        cnt_d    = cnt_q;

        // Key set may only change while no block is in flight
        if (bus.cfg_load) begin
            if ((state_q == S_IDLE) && len_ok_c) begin
                key_d  = bus.cfg_key;
                klen_d = bus.cfg_key_length;
            end else begin
                cfgerr_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    pt_d    = bus.s_data;
                    enc_d   = bus.s_encrypt;
                    en_d    = 1'b1;
                    wd_d    = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.core_ready) begin
                    mdata_d  = bus.core_cipher;
                    menc_d   = enc_q;
                    mvalid_d = 1'b1;
                    en_d     = 1'b0;
                    cnt_d    = cnt_q + 16'd1;
                    state_d  = S_OUT;
                end else if (wd_last_c) begin
                    tmo_d   = 1'b1;
                    en_d    = 1'b0;
                    gap_d   = '0;
                    state_d = S_GAP;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_OUT: begin
                if (bus.m_ready) begin
                    mvalid_d = 1'b0;
                    gap_d    = '0;
                    state_d  = S_GAP;
                end
            end
            S_GAP: begin
                // A core still signalling ready holds us here indefinitely
                if (gap_done_c && !bus.core_ready) begin
                    state_d = S_IDLE;
                end else if (!gap_done_c) begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.s_ready         = s_ready_c;
    assign bus.cfg_err         = cfgerr_q;
    assign bus.m_valid         = mvalid_q;
    assign bus.m_data          = mdata_q;
    assign bus.m_encrypt       = menc_q;
    assign bus.core_enable     = en_q;
    assign bus.core_encrypt    = enc_q;
    assign bus.core_plaintext  = pt_q;
    assign bus.core_key        = key_q;
    assign bus.core_key_length = klen_q;
    assign bus.err_timeout     = tmo_q;
    assign bus.blk_count       = cnt_q;

endmodule

// File: tb/tb_blowfish128_host_driver.sv
// Directed bench for blowfish128_host_driver with a fixed-latency core stub.
module tb_blowfish128_host_driver;

    localparam int LAT = 16;
    localparam logic [63:0]  KEY0 = 64'haabb_0918_2736_ccdd;
    localparam logic [127:0] PT   = 128'h123456abcd132536_123456abcd132536;
    localparam logic [127:0] CT   = 128'h123456abcd132536_b88f5fb3ea25e9ec;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    bit   hang;
    int   stick;
    int   st_cnt;
    int   hold_cnt;

    blowfish128_host_driver_if bus ();

    blowfish128_host_driver #(.GAP_CYCLES(2), .TIMEOUT(1024)) dut (
        .Clk  (clk),
        .RstN (rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] stub_f(logic [127:0] d, logic e, logic [127:0] k);
        return e ? ((d ^ k) + 128'd1) : ((d - 128'd1) ^ k);
    endfunction

    // Core stub: ready LAT enabled cycles after Enable rises, optionally stuck high
    always @(posedge clk) begin
        if (!rst_n) begin
            bus.core_ready  <= 1'b0;
            bus.core_cipher <= '0;
            st_cnt          <= 0;
            hold_cnt        <= 0;
        end else if (bus.core_enable) begin
            hold_cnt <= 0;
            if (!hang && st_cnt == LAT - 1) begin
                bus.core_ready  <= 1'b1;
                bus.core_cipher <= stub_f(bus.core_plaintext, bus.core_encrypt, bus.core_key[127:0]);
            end
            st_cnt <= st_cnt + 1;
        end else begin
            st_cnt <= 0;
            if (bus.core_ready && hold_cnt < stick) hold_cnt <= hold_cnt + 1;
            else bus.core_ready <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_block(input logic [127:0] d, input logic e);
        int n = 0;
        while (!bus.s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("s_ready_wait", 512'(bus.s_ready), 512'd1);
        bus.s_valid   = 1'b1;
        bus.s_data    = d;
        bus.s_encrypt = e;
        @(posedge clk);
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic collect(input logic [127:0] exp_d, input logic exp_e,
                           input logic [15:0] exp_cnt, input int hold);
        int n = 0;
        bit ok = 1'b1;
        while (!bus.m_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("m_valid", 512'(bus.m_valid), 512'd1);
        check("m_data", 512'(bus.m_data), 512'(exp_d));
        check("m_encrypt", 512'(bus.m_encrypt), 512'(exp_e));
        check("blk_count", 512'(bus.blk_count), 512'(exp_cnt));
        check("en_low_out", 512'(bus.core_enable), 512'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            ok &= bus.m_valid && (bus.m_data == exp_d) && !bus.s_ready;
        end
        if (hold > 0) check("bp_stable", 512'(ok), 512'd1);
        bus.m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.m_ready = 1'b0;
        check("m_valid_drop", 512'(bus.m_valid), 512'd0);
    endtask

    initial begin
        int  n;
        bit  flag;
        bit  seen;
        total = 0;
        bad   = 0;
        hang  = 1'b0;
        stick = 0;
        rst_n = 1'b0;
        bus.cfg_load       = 1'b0;
        bus.cfg_key        = '0;
        bus.cfg_key_length = '0;
        bus.s_valid        = 1'b0;
        bus.s_data         = '0;
        bus.s_encrypt      = 1'b0;
        bus.m_ready        = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_s_ready", 512'(bus.s_ready), 512'd0);
        check("rst_enable", 512'(bus.core_enable), 512'd0);
        check("rst_m_valid", 512'(bus.m_valid), 512'd0);
        check("rst_key", bus.core_key, 512'd0);
        check("rst_count", 512'(bus.blk_count), 512'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Key load and block offered in the same cycle: load wins
        bus.cfg_load       = 1'b1;
        bus.cfg_key        = 512'(KEY0);
        bus.cfg_key_length = 4'd2;
        bus.s_valid        = 1'b1;
        bus.s_data         = PT;
        bus.s_encrypt      = 1'b1;
        #1;
        check("load_blocks_s_ready", 512'(bus.s_ready), 512'd0);
        @(posedge clk);
        @(negedge clk);
        bus.cfg_load = 1'b0;
        check("key_loaded", bus.core_key, 512'(KEY0));
        check("klen_loaded", 512'(bus.core_key_length), 512'd2);
        check("not_accepted", 512'(bus.core_enable), 512'd0);
        check("cfg_err_legal", 512'(bus.cfg_err), 512'd0);
        @(posedge clk);
        @(negedge clk);
        bus.s_valid = 1'b0;
        check("enable_rise", 512'(bus.core_enable), 512'd1);
        check("core_pt", 512'(bus.core_plaintext), 512'(PT));
        check("core_enc", 512'(bus.core_encrypt), 512'd1);

        // m_valid exactly one cycle after core_ready
        n = 0;
        while (!bus.core_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("core_ready_seen", 512'(bus.core_ready), 512'd1);
        check("m_valid_early", 512'(bus.m_valid), 512'd0);
        @(negedge clk);
        check("m_valid_next", 512'(bus.m_valid), 512'd1);
        collect(CT, 1'b1, 16'd1, 0);

        // Decrypt the result under 10 cycles of backpressure, then time the gap
        send_block(CT, 1'b0);
        collect(PT, 1'b0, 16'd2, 10);
        check("gap_cycle1", 512'(bus.s_ready), 512'd0);
        @(negedge clk);
        check("gap_cycle2", 512'(bus.s_ready), 512'd0);
        @(negedge clk);
        check("gap_done", 512'(bus.s_ready), 512'd1);

        // Illegal key length
        bus.cfg_load       = 1'b1;
        bus.cfg_key        = '1;
        bus.cfg_key_length = 4'd0;
        @(posedge clk);
        @(negedge clk);
        bus.cfg_load = 1'b0;
        check("len0_err", 512'(bus.cfg_err), 512'd1);
        check("len0_key", bus.core_key, 512'(KEY0));
        @(negedge clk);
        check("len0_err_pulse", 512'(bus.cfg_err), 512'd0);

        // Key load while a block is running
        send_block(PT, 1'b1);
        bus.cfg_load       = 1'b1;
        bus.cfg_key_length = 4'd3;
        @(posedge clk);
        @(negedge clk);
        bus.cfg_load = 1'b0;
        check("run_load_err", 512'(bus.cfg_err), 512'd1);
        check("run_load_klen", 512'(bus.core_key_length), 512'd2);
        check("run_load_key", bus.core_key, 512'(KEY0));
        collect(CT, 1'b1, 16'd3, 0);

        // Hung core: watchdog aborts after 1024 RUN cycles
        hang = 1'b1;
        send_block(PT, 1'b1);
        n = 0;
        seen = 1'b0;
        while (bus.core_enable && n < 2000) begin
            seen |= bus.m_valid;
            @(negedge clk);
            n++;
        end
        check("tmo_run_cycles", 512'(n), 512'd1024);
        check("tmo_err", 512'(bus.err_timeout), 512'd1);
        check("tmo_no_m_valid", 512'(seen | bus.m_valid), 512'd0);
        check("tmo_count", 512'(bus.blk_count), 512'd3);
        hang = 1'b0;
        send_block(PT, 1'b1);
        collect(CT, 1'b1, 16'd4, 0);
        check("tmo_sticky", 512'(bus.err_timeout), 512'd1);

        // core_ready stuck high after capture holds the gap
        stick = 5;
        send_block(PT, 1'b1);
        collect(CT, 1'b1, 16'd5, 0);
        n = 0;
        flag = 1'b1;
        seen = 1'b0;
        while (!bus.s_ready && n < 50) begin
            @(negedge clk);
            n++;
            seen |= bus.m_valid;
            flag &= !(bus.s_ready && bus.core_ready);
        end
        check("stuck_gap_len", 512'(n), 512'd6);
        check("stuck_no_early", 512'(flag), 512'd1);
        check("stuck_single", 512'(seen), 512'd0);
        check("stuck_count", 512'(bus.blk_count), 512'd5);
        stick = 0;

        // Reset in the middle of RUN
        send_block(PT, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_enable", 512'(bus.core_enable), 512'd0);
        check("mid_rst_s_ready", 512'(bus.s_ready), 512'd0);
        check("mid_rst_pt", 512'(bus.core_plaintext), 512'd0);
        check("mid_rst_tmo", 512'(bus.err_timeout), 512'd0);
        check("mid_rst_key", bus.core_key, 512'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_count", 512'(bus.blk_count), 512'd0);
        check("post_rst_klen", 512'(bus.core_key_length), 512'd0);
        check("post_rst_s_ready", 512'(bus.s_ready), 512'd1);
        bus.cfg_load       = 1'b1;
        bus.cfg_key        = 512'(KEY0);
        bus.cfg_key_length = 4'd2;
        @(posedge clk);
        @(negedge clk);
        bus.cfg_load = 1'b0;
        send_block(PT, 1'b1);
        collect(CT, 1'b1, 16'd1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/blowfish128_host_driver.md
Name: blowfish128_host_driver

Overview:
- Host-side initiator for the blowfish128_top core.
- Accepts 128-bit blocks over a valid/ready stream and drives the core's Enable/Encrypt/plainText/key inputs.
- Waits for cipherReady, captures cipherText and returns it on an output valid/ready stream.
- Enforces the Enable-low gap the core requires between operations, holds the programmed key set, and recovers from a hung core with a watchdog.

Parameters:
- GAP_CYCLES, 2: minimum cycles core_enable stays low between operations.
- TIMEOUT, 1024: cycles in RUN without core_ready before abort.

Ports:
- Clk  in  1  clock, all logic on rising edge
- RstN  in  1  synchronous active-low reset
- cfg_load  in  1  load key set (single-cycle strobe)
- cfg_key  in  512  key7..key0, key0 in [63:0]
- cfg_key_length  in  4  key length in 64-bit words, legal 1..8
- cfg_err  out  1  one-cycle pulse: illegal length or cfg_load outside IDLE
- s_valid  in  1  input block valid
- s_ready  out  1  driver can accept a block
- s_data  in  128  plaintext or ciphertext block
- s_encrypt  in  1  1 = encrypt, 0 = decrypt
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts result
- m_data  out  128  core result
- m_encrypt  out  1  direction of m_data
- core_enable  out  1  to core Enable
- core_encrypt  out  1  to core Encrypt
- core_plaintext  out  128  to core plainText
- core_key  out  512  to core key0..key7
- core_key_length  out  4  to core key_length
- core_cipher  in  128  from core cipherText
- core_ready  in  1  from core cipherReady
- err_timeout  out  1  sticky, cleared only by reset
- blk_count  out  16  completed blocks, wraps 0xFFFF -> 0

Behaviour:
- Reset (RstN=0 at rising edge):
  - State -> IDLE.
  - All outputs 0 and all registers 0, including key and key length.
  - s_ready=0 while RstN=0.
  - Reset mid-operation aborts immediately; any in-flight result is discarded.
- States: IDLE, RUN, OUT, GAP.
- IDLE:
  - s_ready = !cfg_load (key load has priority).
  - On cfg_load with length in 1..8: key regs updated at the edge.
  - On cfg_load with length 0 or 9..15: regs unchanged, cfg_err=1 next cycle.
  - On s_valid&&s_ready: latch s_data and s_encrypt into core_plaintext/core_encrypt; go to RUN. core_enable=1 from the next cycle (1-cycle accept latency).
- RUN:
  - core_enable=1; core_plaintext, core_encrypt and core_key stable.
  - Watchdog counts cycles from 0.
  - core_ready=1 at edge r:
    - m_data <= core_cipher, m_encrypt <= core_encrypt.
    - m_valid=1 and core_enable=0 from r+1.
    - blk_count++.
    - Go to OUT.
  - Watchdog reaches TIMEOUT-1 with no core_ready: err_timeout<=1, core_enable<=0, block dropped (no m_valid, no count), go to GAP.
- OUT:
  - m_valid held with m_data/m_encrypt stable until m_ready=1.
  - On m_valid&&m_ready go to GAP; m_valid=0 next cycle.
- GAP:
  - core_enable=0, s_ready=0; gap counter runs.
  - Return to IDLE when at least GAP_CYCLES cycles have elapsed AND core_ready=0.
  - A core_ready stuck high holds GAP indefinitely (no timeout in GAP).
- cfg_load in RUN/OUT/GAP: ignored, cfg_err pulse.
- s_ready never asserts outside IDLE (one block in flight).
- Best case back-to-back throughput: 1 (accept) + core latency + 1 (OUT with m_ready=1) + GAP_CYCLES.
- blk_count wraps silently.
- s_valid held while s_ready=0 is not consumed; s_data may change while s_valid=0.

Test Plan:
- Encrypt, then decrypt the result. Setup: core stub with 16-cycle latency, cfg_key[63:0]=64'haabb_0918_2736_ccdd, length 2, s_data=128'h123456abcd1325361234_56abcd132536, s_encrypt=1. Required response:
  - core_enable rises 1 cycle after accept; m_valid exactly 1 cycle after core_ready; m_data equals stub output; blk_count=1.
  - Feeding m_data back with s_encrypt=0 returns the original plaintext; blk_count=2.
- Backpressure: hold m_ready=0 for 10 cycles -> m_valid and m_data stable, s_ready=0 throughout; m_ready=1 -> GAP, then s_ready=1 after exactly GAP_CYCLES=2 cycles.
- Config rules:
  - cfg_load with length 0 -> cfg_err pulse, core_key unchanged.
  - cfg_load during RUN -> cfg_err, key unchanged.
  - cfg_load and s_valid in the same IDLE cycle -> key loaded, block not accepted that cycle.
- Timeout: stub never raises core_ready, TIMEOUT=1024 -> core_enable drops after 1024 RUN cycles, err_timeout=1 sticky, no m_valid, blk_count unchanged; the next block completes normally.
- Stuck ready: stub keeps core_ready=1 for 5 cycles after capture -> driver stays in GAP until core_ready=0, then returns to IDLE; only one result is produced.
- Reset: RstN=0 mid-RUN -> next cycle all outputs 0; after release, key must be reloaded and blk_count=0.
